// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce filter array.
package debounce_pkg;

    // Filter mode selectors
    localparam int MODE_WINDOW    = 0;  // unanimous DEPTH-sample window
    localparam int MODE_INTEGRATE = 1;  // saturating up/down integrator

    // Ceiling log2, usable in constant expressions: clog2(1)=0, clog2(4)=2, clog2(5)=3
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Register width needed to count 0..value-1, never narrower than one bit
    function automatic int count_width(input int value);
        int w;
        w = clog2(value);
        return (w > 1) ? w : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: decision state (window history or integrator), the
// filtered level, and registered rise/fall event pulses. The channel only
// advances on the shared sample tick; between ticks everything holds and the
// event pulses are cleared so each event is exactly one clock wide.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int MODE  = MODE_WINDOW,
    parameter int DEPTH = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic s,
    output logic sig_out,
    output logic rise,
    output logic fall
);

    // Level the channel would take on this tick; holds sig_out when undecided
    logic out_next;

    generate
        if (MODE == MODE_WINDOW) begin : g_window
            // hist[DEPTH-2] is the newest stored sample, hist[0] the oldest
            logic [DEPTH-2:0] hist;
            logic [DEPTH-1:0] win;
            logic             win_out;

            // Unanimous decision over the current sample plus the stored history
            always_comb begin
                win     = {s, hist};
                win_out = sig_out;
                if (&win) begin
                    win_out = 1'b1;
                end else if (~|win) begin
                    win_out = 1'b0;
                end
            end

            // Shift the current sample in and drop the oldest one on each tick
            always_ff @(posedge clock) begin
                if (reset) begin
                    hist <= '0;
                end else if (tick) begin
                    hist <= win[DEPTH-1:1];
                end
            end

            assign out_next = win_out;
        end else begin : g_integrate
            localparam int ACC_W = clog2(DEPTH + 1);
            localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(DEPTH);

            logic [ACC_W-1:0] acc;
            logic [ACC_W-1:0] acc_next;
            logic             int_out;

            // Saturating step toward the sample; the output follows the stepped value
            always_comb begin
                acc_next = acc;
                if (s) begin
                    if (acc != ACC_MAX) begin
                        acc_next = acc + ACC_W'(1);
                    end
                end else begin
                    if (acc != '0) begin
                        acc_next = acc - ACC_W'(1);
                    end
                end
                int_out = sig_out;
                if (acc_next == ACC_MAX) begin
                    int_out = 1'b1;
                end else if (acc_next == '0) begin
                    int_out = 1'b0;
                end
            end

            // Integrator register, advanced only on sample ticks
            always_ff @(posedge clock) begin
                if (reset) begin
                    acc <= '0;
                end else if (tick) begin
                    acc <= acc_next;
                end
            end

            assign out_next = int_out;
        end
    endgenerate

    // Filtered level and edge events; reset clears the level without a fall pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            sig_out <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else if (tick) begin
            sig_out <= out_next;
            rise    <= out_next & ~sig_out;
            fall    <= ~out_next & sig_out;
        end else begin
            rise    <= 1'b0;
            fall    <= 1'b0;
        end
    end

endmodule

// File: rtl/debounce_filter_array.sv
// N-channel glitch/debounce filter. Holds the shared sample prescaler and the
// per-channel input synchronisers; each channel's decision logic lives in
// debounce_channel and all channels advance on the same tick.
module debounce_filter_array
    import debounce_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 3,
    parameter int MODE        = MODE_WINDOW,
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int CNT_W = count_width(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    // Reject illegal configurations at elaboration rather than at run time
    generate
        if (CHANNELS < 1 || DEPTH < 2 || PRESCALE < 1 || SYNC_STAGES < 0 ||
            (MODE != MODE_WINDOW && MODE != MODE_INTEGRATE)) begin : g_bad_params
            $error("debounce_filter_array: illegal parameter value");
        end
    endgenerate

    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic [CHANNELS-1:0] s;

    // Sample prescaler: counts 0..PRESCALE-1 and ticks on the last count
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = sig_in;
        end else begin : g_sync
            logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

            // Synchroniser shift chain; stage 0 captures the raw asynchronous inputs
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= sig_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Independent filter per channel, all sharing the one sample tick
    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
            debounce_channel #(
                .MODE  (MODE),
                .DEPTH (DEPTH)
            ) u_channel (
                .clock   (clock),
                .reset   (reset),
                .tick    (tick),
                .s       (s[ch]),
                .sig_out (sig_out[ch]),
                .rise    (rise[ch]),
                .fall    (fall[ch])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_filter_array.sv
// Bench for debounce_filter_array. Three instances cover the default window
// filter, the saturating integrator and a prescaled, unsynchronised window.
// Expected output words {sig_out, rise, fall} are queued per clock when the
// stimulus is planned, then popped and compared after each rising edge.
module tb_debounce_filter_array;

    localparam int W = 12;

    logic clock;
    logic rst_a, rst_b, rst_c;

    // Instance A: defaults (4 channels, window, DEPTH 3, PRESCALE 1, 2 sync stages)
    logic [3:0] a_in, a_out, a_rise, a_fall;
    // Instance B: integrator, DEPTH 4, no synchroniser
    logic [0:0] b_in, b_out, b_rise, b_fall;
    // Instance C: window, DEPTH 3, PRESCALE 4, no synchroniser
    logic [0:0] c_in, c_out, c_rise, c_fall;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    debounce_filter_array dut_a (
        .clock   (clock),
        .reset   (rst_a),
        .sig_in  (a_in),
        .sig_out (a_out),
        .rise    (a_rise),
        .fall    (a_fall)
    );

    debounce_filter_array #(
        .CHANNELS    (1),
        .DEPTH       (4),
        .MODE        (1),
        .PRESCALE    (1),
        .SYNC_STAGES (0)
    ) dut_b (
        .clock   (clock),
        .reset   (rst_b),
        .sig_in  (b_in),
        .sig_out (b_out),
        .rise    (b_rise),
        .fall    (b_fall)
    );

    debounce_filter_array #(
        .CHANNELS    (1),
        .DEPTH       (3),
        .MODE        (0),
        .PRESCALE    (4),
        .SYNC_STAGES (0)
    ) dut_c (
        .clock   (clock),
        .reset   (rst_c),
        .sig_in  (c_in),
        .sig_out (c_out),
        .rise    (c_rise),
        .fall    (c_fall)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [W-1:0] obs;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_in = '0; b_in = '0; c_in = '0;
        repeat (3) @(negedge clock);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        obs = {a_out, a_rise, a_fall};
        n_checks++;
        if (obs !== exp_q.pop_front()) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 000", obs);
        end
        obs = {9'b0, b_out, b_rise, b_fall};
        n_checks++;
        if (obs !== exp_q.pop_front()) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 000", obs);
        end
        obs = {9'b0, c_out, c_rise, c_fall};
        n_checks++;
        if (obs !== exp_q.pop_front()) begin
            n_fail++;
            $display("FAIL reset_c: got %h expected 000", obs);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // ch0 steps 0->1: level and rise appear on the 5th edge only
    task automatic test_single_step();
        logic [W-1:0] obs, exp;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back({(i >= 5) ? 4'b0001 : 4'b0000,
                             (i == 5) ? 4'b0001 : 4'b0000, 4'b0000});
        end
        a_in = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            obs = {a_out, a_rise, a_fall};
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_step edge %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    // 2-clock glitch on ch1 never reaches its output
    task automatic test_glitch();
        logic [W-1:0] obs, exp;
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back({4'b0001, 4'b0000, 4'b0000});
        end
        a_in[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            obs = {a_out, a_rise, a_fall};
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL glitch edge %0d: got %h expected %h", i, obs, exp);
            end
            if (i == 2) a_in[1] = 1'b0;
        end
    endtask

    // ch2 qualifies high, then ch2 falls and ch3 rises on the same edge
    task automatic test_opposite_steps();
        logic [W-1:0] obs, exp;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back({(i >= 5) ? 4'b0101 : 4'b0001,
                             (i == 5) ? 4'b0100 : 4'b0000, 4'b0000});
        end
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back({(i >= 5) ? 4'b1001 : 4'b0101,
                             (i == 5) ? 4'b1000 : 4'b0000,
                             (i == 5) ? 4'b0100 : 4'b0000});
        end
        a_in[2] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            obs = {a_out, a_rise, a_fall};
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL opposite_steps cycle %0d: got %h expected %h", i, obs, exp);
            end
            if (i == 8) begin
                a_in[2] = 1'b0;
                a_in[3] = 1'b1;
            end
        end
    endtask

    // All channels high, 1-clock reset: outputs clear with no fall, then requalify
    task automatic test_reset_mid();
        logic [W-1:0] obs, exp;
        a_in = 4'b1111;
        repeat (8) @(negedge clock);
        exp_q.push_back({4'b1111, 4'b0000, 4'b0000});
        obs = {a_out, a_rise, a_fall};
        n_checks++;
        exp = exp_q.pop_front();
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_before: got %h expected %h", obs, exp);
        end
        exp_q.push_back(12'h000);
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back({(i >= 5) ? 4'b1111 : 4'b0000,
                             (i == 5) ? 4'b1111 : 4'b0000, 4'b0000});
        end
        rst_a = 1'b1;
        @(negedge clock);
        rst_a = 1'b0;
        obs = {a_out, a_rise, a_fall};
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_edge: got %h expected %h", obs, exp);
        end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            obs = {a_out, a_rise, a_fall};
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_requalify edge %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    // Integrator DEPTH 4: rise on the 6th sample, saturation at 4 bounds the fall delay
    task automatic test_integrator();
        logic [W-1:0] obs, exp;
        logic pat     [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic exp_lvl [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({9'b0, exp_lvl[i], (i == 5) ? 1'b1 : 1'b0, (i == 11) ? 1'b1 : 1'b0});
        end
        for (int i = 0; i < 12; i++) begin
            b_in = pat[i];
            @(negedge clock);
            obs = {9'b0, b_out, b_rise, b_fall};
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL integrator sample %0d: got %h expected %h", i + 1, obs, exp);
            end
        end
    endtask

    // PRESCALE 4: ticks on edges 4, 8, 12; rise on edge 12; off-tick dip ignored
    task automatic test_prescale();
        logic [W-1:0] obs, exp;
        for (int i = 1; i <= 14; i++) begin
            exp_q.push_back({9'b0, (i >= 12) ? 1'b1 : 1'b0, (i == 12) ? 1'b1 : 1'b0, 1'b0});
        end
        rst_c = 1'b1;
        @(negedge clock);
        rst_c = 1'b0;
        c_in  = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clock);
            obs = {9'b0, c_out, c_rise, c_fall};
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL prescale edge %0d: got %h expected %h", i, obs, exp);
            end
            if (i == 4) c_in = 1'b0;
            if (i == 6) c_in = 1'b1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_step();
        test_glitch();
        test_opposite_steps();
        test_reset_mid();
        test_integrator();
        test_prescale();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        n_checks++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
